// File: rtl/branch_unit_if.sv
// Signal bundle between the controller/datapath and the branch unit.
// The master side issues flags and branch requests; the slave side returns results.
interface branch_unit_if #(
  parameter int PCW = 9,
  parameter int IMW = 8
);
  logic           loads;
  logic           Z_in;
  logic           V_in;
  logic           N_in;
  logic           req;
  logic [2:0]     cond;
  logic [IMW-1:0] im8;
  logic [PCW-1:0] pc_in;
  logic [PCW-1:0] rd_val;
  logic [2:0]     status;
  logic           busy;
  logic           done;
  logic           taken;
  logic [PCW-1:0] pc_next;
  logic           link_we;
  logic [PCW-1:0] link_val;

  modport master (
    output loads, Z_in, V_in, N_in, req, cond, im8, pc_in, rd_val,
    input  status, busy, done, taken, pc_next, link_we, link_val
  );

  modport slave (
    input  loads, Z_in, V_in, N_in, req, cond, im8, pc_in, rd_val,
    output status, busy, done, taken, pc_next, link_we, link_val
  );
endinterface

// File: rtl/branch_unit.sv
// Branch resolver: holds the {Z,V,N} status register and turns a branch request
// into a registered taken/pc_next/link result two cycles after acceptance.
module branch_unit #(
  parameter int PCW = 9,
  parameter int IMW = 8
) (
  input logic         clk,
  input logic         reset,
  branch_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t                state;
  logic [2:0]            cond_p1;
  logic [2:0]            flags_p1;
  logic signed [IMW-1:0] im_p1;
  logic [PCW-1:0]        pc_p1;
  logic [PCW-1:0]        rd_p1;

  // flags are packed {Z,V,N}, matching the status register layout
  function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'b001:  return z;
      3'b010:  return !z;
      3'b011:  return n ^ v;
      3'b100:  return (n ^ v) | z;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [PCW-1:0] next_pc(input logic [2:0]            c,
                                             input logic [2:0]            f,
                                             input logic [PCW-1:0]        pc,
                                             input logic signed [IMW-1:0] im,
                                             input logic [PCW-1:0]        rd);
    logic [PCW-1:0]        seq;
    logic signed [PCW-1:0] off;
    seq = pc + PCW'(1);
    off = PCW'(im);
    if (c[2:1] == 2'b11) return rd;
    if (!cond_met(c, f)) return seq;
    return seq + off;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cond_p1      <= '0;
      flags_p1     <= '0;
      im_p1        <= '0;
      pc_p1        <= '0;
      rd_p1        <= '0;
      bus.status   <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.taken    <= 1'b0;
      bus.pc_next  <= '0;
      bus.link_we  <= 1'b0;
      bus.link_val <= '0;
    end else begin
      if (bus.loads) bus.status <= {bus.Z_in, bus.V_in, bus.N_in};
      bus.done    <= 1'b0;
      bus.link_we <= 1'b0;
      case (state)
        // p1 capture: the snapshot takes the pre-edge status, so a coincident load is not seen
        IDLE: begin
          if (bus.req) begin
            cond_p1  <= bus.cond;
            im_p1    <= bus.im8;
            pc_p1    <= bus.pc_in;
            rd_p1    <= bus.rd_val;
            flags_p1 <= bus.status;
            bus.busy <= 1'b1;
            state    <= EVAL;
          end
        end
        // p2 result: registered outputs hold until the next request reaches this point
        EVAL: begin
          bus.taken    <= cond_met(cond_p1, flags_p1);
          bus.pc_next  <= next_pc(cond_p1, flags_p1, pc_p1, im_p1, rd_p1);
          bus.link_val <= pc_p1 + PCW'(1);
          bus.link_we  <= (cond_p1 == 3'b101) || (cond_p1 == 3'b111);
          bus.done     <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Scenario bench for branch_unit: expected results are queued as each request is
// driven and compared against the DUT when done arrives.
module tb_branch_unit;

  typedef struct packed {
    logic       taken;
    logic [8:0] pc_next;
    logic       link_we;
    logic [8:0] link_val;
  } res_t;

  typedef struct packed {
    logic [2:0] f;
    logic [2:0] c;
    logic [7:0] im;
    logic [8:0] pc;
    logic [8:0] rd;
    res_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  res_t got, exp_r;
  int   lat;
  logic [2:0] st1;

  branch_unit_if #(.PCW(9), .IMW(8)) bus();

  branch_unit #(.PCW(9), .IMW(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic z, input logic v, input logic n);
    bus.loads = 1'b1;
    bus.Z_in  = z;
    bus.V_in  = v;
    bus.N_in  = n;
    step();
    bus.loads = 1'b0;
  endtask

  // drives one request and collects what the DUT returns; no judging here
  task automatic run_branch(input logic [2:0] c, input logic [7:0] im, input logic [8:0] pc,
                            input logic [8:0] rd, input bit hold,
                            output res_t r, output int l, output logic [2:0] s1);
    bus.req    = 1'b1;
    bus.cond   = c;
    bus.im8    = im;
    bus.pc_in  = pc;
    bus.rd_val = rd;
    step();
    bus.loads = 1'b0;
    if (!hold) bus.req = 1'b0;
    s1 = bus.status;
    l  = 1;
    while (bus.done !== 1'b1 && l < 8) begin
      step();
      l++;
    end
    r = {bus.taken, bus.pc_next, bus.link_we, bus.link_val};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({bus.status, bus.busy, bus.done, bus.taken, bus.pc_next, bus.link_we, bus.link_val} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {bus.status, bus.busy, bus.done, bus.taken,
               bus.pc_next, bus.link_we, bus.link_val});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_conditions();
    vec_t v[4];
    v[0] = '{f:3'b100, c:3'b001, im:8'h05, pc:9'h010, rd:9'h000, e:'{1'b1, 9'h016, 1'b0, 9'h011}};
    v[1] = '{f:3'b100, c:3'b010, im:8'h05, pc:9'h010, rd:9'h000, e:'{1'b0, 9'h011, 1'b0, 9'h011}};
    v[2] = '{f:3'b001, c:3'b011, im:8'hFE, pc:9'h020, rd:9'h000, e:'{1'b1, 9'h01F, 1'b0, 9'h021}};
    v[3] = '{f:3'b011, c:3'b100, im:8'hFE, pc:9'h020, rd:9'h000, e:'{1'b0, 9'h021, 1'b0, 9'h021}};
    for (int i = 0; i < 4; i++) begin
      set_flags(v[i].f[2], v[i].f[1], v[i].f[0]);
      checks++;
      if (bus.status !== v[i].f) begin
        errors++;
        $display("FAIL cond_status[%0d]: got %b required %b", i, bus.status, v[i].f);
      end
      sb.push_back(v[i].e);
      run_branch(v[i].c, v[i].im, v[i].pc, v[i].rd, 1'b0, got, lat, st1);
      exp_r = sb.pop_front();
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL cond_latency[%0d]: got %0d required 2", i, lat);
      end
      checks++;
      if (got !== exp_r) begin
        errors++;
        $display("FAIL cond_result[%0d]: got %h required %h", i, got, exp_r);
      end
    end
    step();
    checks++;
    if ({bus.busy, bus.done, bus.link_we, bus.pc_next} !== {3'b000, 9'h021}) begin
      errors++;
      $display("FAIL after_done_hold: got %h required %h", {bus.busy, bus.done, bus.link_we, bus.pc_next},
               {3'b000, 9'h021});
    end
  endtask

  task automatic test_wrap();
    vec_t v[2];
    v[0] = '{f:3'b000, c:3'b000, im:8'h01, pc:9'h1FF, rd:9'h000, e:'{1'b1, 9'h001, 1'b0, 9'h000}};
    v[1] = '{f:3'b000, c:3'b000, im:8'h80, pc:9'h000, rd:9'h000, e:'{1'b1, 9'h181, 1'b0, 9'h001}};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(v[i].e);
      run_branch(v[i].c, v[i].im, v[i].pc, v[i].rd, 1'b0, got, lat, st1);
      exp_r = sb.pop_front();
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL wrap_latency[%0d]: got %0d required 2", i, lat);
      end
      checks++;
      if (got !== exp_r) begin
        errors++;
        $display("FAIL wrap_result[%0d]: got %h required %h", i, got, exp_r);
      end
      step();
    end
  endtask

  task automatic test_link();
    vec_t v[3];
    v[0] = '{f:3'b000, c:3'b111, im:8'h00, pc:9'h040, rd:9'h0AB, e:'{1'b1, 9'h0AB, 1'b1, 9'h041}};
    v[1] = '{f:3'b000, c:3'b110, im:8'h00, pc:9'h040, rd:9'h0AB, e:'{1'b1, 9'h0AB, 1'b0, 9'h041}};
    v[2] = '{f:3'b000, c:3'b101, im:8'h10, pc:9'h100, rd:9'h0AB, e:'{1'b1, 9'h111, 1'b1, 9'h101}};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(v[i].e);
      run_branch(v[i].c, v[i].im, v[i].pc, v[i].rd, 1'b0, got, lat, st1);
      exp_r = sb.pop_front();
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL link_latency[%0d]: got %0d required 2", i, lat);
      end
      checks++;
      if (got !== exp_r) begin
        errors++;
        $display("FAIL link_result[%0d]: got %h required %h", i, got, exp_r);
      end
      step();
      checks++;
      if (bus.link_we !== 1'b0) begin
        errors++;
        $display("FAIL link_pulse_width[%0d]: got %b required 0", i, bus.link_we);
      end
    end
  endtask

  task automatic test_loads_coincident();
    set_flags(1'b0, 1'b0, 1'b0);
    bus.loads = 1'b1;
    bus.Z_in  = 1'b1;
    bus.V_in  = 1'b0;
    bus.N_in  = 1'b0;
    sb.push_back('{1'b0, 9'h031, 1'b0, 9'h031});
    run_branch(3'b001, 8'h04, 9'h030, 9'h000, 1'b0, got, lat, st1);
    exp_r = sb.pop_front();
    checks++;
    if (st1 !== 3'b100) begin
      errors++;
      $display("FAIL coincident_status: got %b required 100", st1);
    end
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL coincident_result: got %h required %h", got, exp_r);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int extra;
    sb.push_back('{1'b1, 9'h053, 1'b0, 9'h051});
    run_branch(3'b001, 8'h02, 9'h050, 9'h000, 1'b1, got, lat, st1);
    exp_r = sb.pop_front();
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL b2b_result: got %h required %h", got, exp_r);
    end
    step();
    bus.req = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
      step();
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL b2b_extra_activity: got %0d cycles required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    bus.req    = 1'b1;
    bus.cond   = 3'b101;
    bus.im8    = 8'h01;
    bus.pc_in  = 9'h060;
    bus.rd_val = 9'h000;
    step();
    bus.req = 1'b0;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.status, bus.busy, bus.done, bus.taken, bus.pc_next, bus.link_we, bus.link_val} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h required 0", {bus.status, bus.busy, bus.done, bus.taken,
               bus.pc_next, bus.link_we, bus.link_val});
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done === 1'b1 || bus.link_we === 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_pulses: got %0d required 0", pulses);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.loads  = 1'b0;
    bus.Z_in   = 1'b0;
    bus.V_in   = 1'b0;
    bus.N_in   = 1'b0;
    bus.req    = 1'b0;
    bus.cond   = 3'b000;
    bus.im8    = 8'h00;
    bus.pc_in  = 9'h000;
    bus.rd_val = 9'h000;
    test_reset();
    test_conditions();
    test_wrap();
    test_link();
    test_loads_coincident();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Sequential flag-consumer for the ALU's status outputs. It captures Z, V and N into a status register on a load strobe. It evaluates the branch condition of a requested branch against those flags and produces the next PC and link value with a req/done handshake. It sits between the datapath (ALU flags, PC, register-file read value) and the controller FSM, which issues branch requests and waits for done.

## Interface
Parameters:
- PCW, 9, PC/address width
- IMW, 8, branch offset width (sign-extended to PCW)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- loads  in  1  load status register from Z_in/V_in/N_in this edge
- Z_in, V_in, N_in  in  1 each  ALU flags
- req  in  1  branch request, sampled only in IDLE
- cond  in  3  branch kind: 000 B, 001 BEQ, 010 BNE, 011 BLT, 100 BLE, 101 BL, 110 BX, 111 BLX
- im8  in  IMW  signed PC-relative offset
- pc_in  in  PCW  PC of the branch instruction
- rd_val  in  PCW  register target for BX/BLX
- status  out  3  {Z,V,N} status register
- busy  out  1  high in EVAL and DONE
- done  out  1  one-cycle pulse, results valid
- taken  out  1  branch taken
- pc_next  out  PCW  next PC
- link_we  out  1  one-cycle pulse coincident with done for BL/BLX
- link_val  out  PCW  return address pc_in+1

## Operation
- Status register: on an edge with loads=1, status <= {Z_in,V_in,N_in}. This happens in any FSM state and is otherwise held.
- FSM states are IDLE, EVAL and DONE.
  - IDLE -> EVAL on an edge with req=1. At that edge, latch cond, im8, pc_in and rd_val, plus a flag snapshot equal to the pre-edge status value.
  - EVAL -> DONE unconditionally. At this edge, register taken, pc_next, link_val and a link flag.
  - DONE -> IDLE unconditionally.
- req in EVAL/DONE is ignored and is not queued. req in IDLE is accepted again on the edge leaving DONE→IDLE's following cycle, i.e. no back-to-back acceptance closer than 3 cycles.
- Conditions use the snapshot Z, V, N:
  - B, BL, BX, BLX: always taken.
  - BEQ: Z.
  - BNE: !Z.
  - BLT: N^V.
  - BLE: (N^V)|Z.
- Arithmetic is modulo 2^PCW with wrap-around and no error.
  - Target = pc_in + 1 + sign_extend(im8).
  - Not taken: pc_next = pc_in + 1.
  - BX/BLX: pc_next = rd_val.
  - link_val = pc_in + 1 for every request. link_we is asserted only for BL/BLX.
- taken, pc_next and link_val hold after done until the next request reaches DONE.
- loads coincident with acceptance: the in-flight request uses the old flags, and status shows the new value next cycle. loads during EVAL/DONE do not affect the in-flight request.

## Timing
- Reset values: state IDLE, status 000, busy 0, done 0, taken 0, pc_next 0, link_we 0, link_val 0, snapshot/latches 0.
- Reset mid-operation (EVAL or DONE) aborts the request. No done or link_we is produced, and all outputs return to reset values the next cycle.
- Reset has priority over loads and req on the same edge.
- Latency: req accepted at edge k. Then busy is high in cycles k+1..k+2, done and link_we are high in cycle k+2 only, and busy is low from cycle k+3.
- All outputs are registered, with no combinational path from inputs to outputs.
- status reflects loads one cycle after the loading edge.

## Test plan
- Reset, loads with Z=1,V=0,N=0. Then BEQ with pc_in=0x010, im8=0x05 → done 2 cycles after acceptance, taken=1, pc_next=0x016, link_we=0, status=3'b100.
- Same flags, BNE with pc_in=0x010 → taken=0, pc_next=0x011. Flags N=1,V=0,Z=0, BLT with pc_in=0x020, im8=0xFE → taken=1, pc_next=0x01F. Flags N=1,V=1,Z=0, BLE → taken=0, pc_next=0x021.
- Wrap: B with pc_in=0x1FF, im8=0x01 → pc_next=0x001. B with pc_in=0x000, im8=0x80 → pc_next=0x181.
- BLX with pc_in=0x040, rd_val=0x0AB → pc_next=0x0AB, taken=1, link_we pulses with done, link_val=0x041. BX → same pc_next, link_we stays 0.
- Status 000, then loads (Z_in=1) on the same edge as a BEQ request → taken=0, status=3'b100 next cycle. A second req asserted during EVAL/DONE produces no extra done.
- BL accepted, reset asserted in EVAL → no done/link_we pulse, and all outputs are 0 the cycle after reset.
